// File: rtl/ram_sp_param.sv
// ram_sp_param: single-port synchronous RAM with separate write/read buses,
// byte enables, registered read with valid strobe, post-reset clear sequencer
// and out-of-range address detection.
// Optional build macro RAM_PARITY_EN: per-byte even parity with ram_perr_o.
module ram_sp_param #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ram_cs_i,
  input  logic                ram_we_i,
  input  logic [DATA_W/8-1:0] ram_be_i,
  input  logic [ADDR_W-1:0]   ram_addr_i,
  input  logic [DATA_W-1:0]   ram_wdata_i,
  output logic [DATA_W-1:0]   ram_rdata_o,
  output logic                ram_rvalid_o,
  output logic                ram_ready_o,
  output logic                ram_oor_o
`ifdef RAM_PARITY_EN
  ,
  output logic                ram_perr_o
`endif
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic                rvalid_reg;
  logic                oor_reg;

  logic                clearing;
  logic                clear_we;
  logic                accept;
  logic                in_range;
  logic                rd_accept;
  logic                wr_accept;
  logic [ADDR_W-1:0]   waddr;

  // Requests only count in READY; the reset edge never writes the array.
  assign clearing  = (state_reg == CLEAR);
  assign clear_we  = clearing && !rst_i;
  assign accept    = (state_reg == READY) && ram_cs_i && !rst_i;
  assign in_range  = ({1'b0, ram_addr_i} < (ADDR_W+1)'(DEPTH));
  assign rd_accept = accept && !ram_we_i;
  assign wr_accept = accept && ram_we_i && in_range;
  assign waddr     = clearing ? ptr_reg : ram_addr_i;

  // Next-state logic: walk the clear pointer through every word, then serve requests.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      CLEAR: begin
        if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = READY;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  // State register plus the rvalid / out-of-range strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= CLEAR;
      ptr_reg    <= '0;
      rvalid_reg <= 1'b0;
      oor_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      rvalid_reg <= rd_accept;
      oor_reg    <= accept && !in_range;
    end
  end

  assign ram_rvalid_o = rvalid_reg;
  assign ram_oor_o    = oor_reg;
  assign ram_ready_o  = (state_reg == READY);

`ifdef RAM_PARITY_EN
  logic [NB-1:0] perr_vec;
  assign ram_perr_o = |perr_vec;
`endif

  // One independent byte lane per enable bit keeps each lane a plain
  // single-writer array with its own registered read.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    logic [7:0] byte_mem_reg [DEPTH];
    logic [7:0] rd_byte_reg;
    logic [7:0] wbyte;
    logic       byte_we;

    assign wbyte   = clearing ? INIT_VAL[8*gi +: 8] : ram_wdata_i[8*gi +: 8];
    assign byte_we = clear_we || (wr_accept && ram_be_i[gi]);

    // Byte lane write port (clear sequencer or enabled request byte).
    always_ff @(posedge clk_i) begin
      if (byte_we) begin
        byte_mem_reg[waddr] <= wbyte;
      end
    end

    // Registered read; out-of-range reads return zero, otherwise value holds.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_byte_reg <= '0;
      end else if (rd_accept) begin
        rd_byte_reg <= in_range ? byte_mem_reg[ram_addr_i] : 8'h00;
      end
    end

    assign ram_rdata_o[8*gi +: 8] = rd_byte_reg;

`ifdef RAM_PARITY_EN
    logic par_mem_reg [DEPTH];
    logic perr_byte_reg;

    // Parity lane written alongside the data byte.
    always_ff @(posedge clk_i) begin
      if (byte_we) begin
        par_mem_reg[waddr] <= ^wbyte;
      end
    end

    // Parity mismatch flag, only raised by in-range reads.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        perr_byte_reg <= 1'b0;
      end else begin
        perr_byte_reg <= rd_accept && in_range &&
                         ((^byte_mem_reg[ram_addr_i]) != par_mem_reg[ram_addr_i]);
      end
    end

    assign perr_vec[gi] = perr_byte_reg;
`endif
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Testbench for ram_sp_param: two instances (DEPTH=16 and DEPTH=12) share one
// stimulus stream; a reference model per instance fills a response scoreboard
// that a separate monitor drains on the falling edge.
module tb_ram_sp_param;

  localparam logic [31:0] INIT = 32'hA5A5_0000;

  typedef struct packed {
    logic        rv;
    logic        oor;
    logic        perr;
    logic [31:0] rd;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata_w  [2];
  logic        rvalid_w [2];
  logic        ready_w  [2];
  logic        oor_w    [2];
`ifdef RAM_PARITY_EN
  logic        perr_w   [2];
`endif

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic        mon_en   = 1'b0;

  // Reference model state
  logic [31:0] mem_m     [2][16];
  logic        corrupt_m [2][16];
  int          clr_m     [2];
  logic        ready_m   [2];
  logic [31:0] last_rd_m [2];
  resp_t       q0[$];
  resp_t       q1[$];

  ram_sp_param #(.DATA_W(32), .DEPTH(16), .INIT_VAL(INIT)) u_d16 (
    .clk_i(clk), .rst_i(rst), .ram_cs_i(cs), .ram_we_i(we), .ram_be_i(be),
    .ram_addr_i(addr), .ram_wdata_i(wdata), .ram_rdata_o(rdata_w[0]),
    .ram_rvalid_o(rvalid_w[0]), .ram_ready_o(ready_w[0]), .ram_oor_o(oor_w[0])
`ifdef RAM_PARITY_EN
    , .ram_perr_o(perr_w[0])
`endif
  );

  ram_sp_param #(.DATA_W(32), .DEPTH(12), .INIT_VAL(INIT)) u_d12 (
    .clk_i(clk), .rst_i(rst), .ram_cs_i(cs), .ram_we_i(we), .ram_be_i(be),
    .ram_addr_i(addr), .ram_wdata_i(wdata), .ram_rdata_o(rdata_w[1]),
    .ram_rvalid_o(rvalid_w[1]), .ram_ready_o(ready_w[1]), .ram_oor_o(oor_w[1])
`ifdef RAM_PARITY_EN
    , .ram_perr_o(perr_w[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (DEPTH=%0d): got %h, expected %h", name, depth_of(k), act, exp);
  endtask

  task automatic push_resp(input int k, input resp_t r);
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Behavioural model: reset fills the array with INIT (the clear makes it so),
  // then DEPTH low-reset edges later requests start being served.
  task automatic model_step(input int k);
    resp_t r;
    int    dep;
    dep = depth_of(k);
    r   = '0;
    if (rst) begin
      clr_m[k]     = 0;
      ready_m[k]   = 1'b0;
      last_rd_m[k] = '0;
      for (int i = 0; i < 16; i++) begin
        mem_m[k][i]     = INIT;
        corrupt_m[k][i] = 1'b0;
      end
    end else if (clr_m[k] < dep) begin
      clr_m[k]++;
      ready_m[k] = (clr_m[k] == dep);
    end else if (cs) begin
      if (int'(addr) < dep) begin
        if (we) begin
          for (int n = 0; n < 4; n++)
            if (be[n]) mem_m[k][addr][8*n +: 8] = wdata[8*n +: 8];
          if (be[1]) corrupt_m[k][addr] = 1'b0;
        end else begin
          r.rv   = 1'b1;
          r.rd   = mem_m[k][addr];
          r.perr = corrupt_m[k][addr];
          last_rd_m[k] = r.rd;
          push_resp(k, r);
        end
      end else begin
        r.oor = 1'b1;
        r.rv  = !we;
        if (!we) last_rd_m[k] = '0;
        push_resp(k, r);
      end
    end
  endtask

  // One clock of stimulus: drive after the falling edge, update the model at the rising edge.
  task automatic cycle(input logic r, input logic c, input logic w, input logic [3:0] b,
                       input logic [3:0] a, input logic [31:0] d);
    rst = r; cs = c; we = w; be = b; addr = a; wdata = d;
    if (c && !r) $display("txn %s addr=%0d be=%h wdata=%h", w ? "WR" : "RD", a, b, d);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    if (r) mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, b, a, d);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(ready_w[0] && ready_w[1]) && n < 40) begin
      idle();
      n++;
    end
    chk_cnt++;
    if (ready_w[0] && ready_w[1]) pass_cnt++;
    else $display("FAIL ready_timeout: got ready=%0d/%0d after %0d cycles, expected 1/1",
                  ready_w[0], ready_w[1], n);
  endtask

  // Monitor: compare ready every cycle, drain the scoreboard on every response.
  task automatic check_inst(input int k);
    resp_t e;
    logic  have;
    chk("ready", k, {31'b0, ready_w[k]}, {31'b0, ready_m[k]});
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (rvalid_w[k] || oor_w[k] || have) begin
      if (!have) begin
        chk_cnt++;
        $display("FAIL unexpected_resp (DEPTH=%0d): got rvalid=%0d oor=%0d, expected none",
                 depth_of(k), rvalid_w[k], oor_w[k]);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("rvalid", k, {31'b0, rvalid_w[k]}, {31'b0, e.rv});
        chk("oor", k, {31'b0, oor_w[k]}, {31'b0, e.oor});
        if (e.rv) chk("rdata", k, rdata_w[k], e.rd);
`ifdef RAM_PARITY_EN
        chk("perr", k, {31'b0, perr_w[k]}, {31'b0, e.perr});
`endif
      end
    end
    if (!rvalid_w[k]) chk("rdata_hold", k, rdata_w[k], last_rd_m[k]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) for (int k = 0; k < 2; k++) check_inst(k);
    end
  end

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);

    // Clear, with write requests that must be ignored, then reset mid-clear.
    for (int i = 0; i < 7; i++) wr(4'(i), 4'hF, 32'h0BAD_0000 + i);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) wr(4'(i + 2), 4'hF, 32'hBAD0_BAD0);
    wait_ready();

    // Every word holds INIT after the clear (DEPTH=12 flags 12..15 as out of range).
    for (int a = 0; a < 16; a++) rd(4'(a));

    // Byte enables.
    wr(4'd3, 4'hF, 32'h1122_3344);
    wr(4'd3, 4'b0101, 32'hFFFF_FFFF);
    wr(4'd3, 4'h0, 32'h0000_0000);
    rd(4'd3);

    // Back-to-back write then reads.
    wr(4'd5, 4'hF, 32'hDEAD_BEEF);
    rd(4'd5);
    rd(4'd6);
    idle();

    // Out-of-range access on the 12-word instance.
    wr(4'd13, 4'hF, 32'h1234_5678);
    rd(4'd13);
    for (int a = 0; a < 12; a++) rd(4'(a));
    wr(4'd15, 4'hF, 32'h5555_AAAA);
    rd(4'd15);

    // Randomised mixed traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);

    // Reset in READY with a simultaneous write, then verify a fresh clear.
    cycle(1'b1, 1'b1, 1'b1, 4'hF, 4'd0, 32'h0BAD_0BAD);
    wr(4'd1, 4'hF, 32'h0BAD_0001);
    wait_ready();
    for (int a = 0; a < 16; a++) rd(4'(a));

`ifdef RAM_PARITY_EN
    // Flip one stored data bit of word 2, byte 1, leaving its parity stale.
    u_d16.g_byte[1].byte_mem_reg[2][0] = ~u_d16.g_byte[1].byte_mem_reg[2][0];
    mem_m[0][2][8]  = ~mem_m[0][2][8];
    corrupt_m[0][2] = 1'b1;
    rd(4'd2);
    rd(4'd3);
`endif

    idle();
    idle();
    @(posedge clk);
    #1;
    chk_cnt = chk_cnt;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM: the next generation of the team's `ram` block, which is verified by the `top`/`test` environment. It replaces the bidirectional data bus with separate write and read buses, and adds byte enables. It also adds a registered read with a valid strobe, an automatic post-reset clear sequencer and out-of-range address detection. It sits behind a single master in the verification environment and in the subsystem memory map.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value ≥ 2, not necessarily a power of 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequencer.

- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ram_cs_i  in  1  request strobe; one access per cycle in which it is high.
- ram_we_i  in  1  1 = write, 0 = read; qualified by ram_cs_i.
- ram_be_i  in  DATA_W/8  byte write enables; bit n covers data bits [8n+7:8n].
- ram_addr_i  in  ADDR_W  word address.
- ram_wdata_i  in  DATA_W  write data.
- ram_rdata_o  out  DATA_W  registered read data.
- ram_rvalid_o  out  1  one-cycle pulse: ram_rdata_o holds a read result.
- ram_ready_o  out  1  high once the clear sequence completes; requests are accepted only while high.
- ram_oor_o  out  1  one-cycle pulse: the accepted request had ram_addr_i ≥ DEPTH.

## Operation
- FSM states are CLEAR and READY.
- Reset forces CLEAR with clear pointer = 0. It also drives ram_rdata_o=0, ram_rvalid_o=0, ram_ready_o=0 and ram_oor_o=0.
- CLEAR: on each edge with rst_i low, the block writes INIT_VAL to word[ptr] and increments ptr.
- When the edge that writes ptr = DEPTH-1 occurs, the FSM moves to READY and ram_ready_o goes to 1.
- Any request in CLEAR is ignored: no write, no rvalid, no oor.
- READY: a request is accepted when ram_cs_i=1.
- Accepted write, addr < DEPTH: only bytes with ram_be_i[n]=1 are updated. be=0 is a legal no-op.
- Accepted read, addr < DEPTH: ram_rdata_o ← word[addr] and ram_rvalid_o ← 1.
- Accepted access with addr ≥ DEPTH:
  - A write is dropped.
  - A read returns ram_rdata_o=0 with ram_rvalid_o=1.
  - In both cases ram_oor_o pulses.
- ram_rdata_o holds its last value when ram_rvalid_o=0. It is never cleared except by reset.
- rst_i asserted mid-CLEAR or in READY aborts immediately and the clear restarts from word 0. A write on the same edge as reset is not performed.
- Back-to-back accesses are sustained at one per cycle in any mix.

## Timing
- The clear takes exactly DEPTH cycles. ram_ready_o rises after the DEPTH-th rising edge at which rst_i is sampled low.
- Read latency is 1: a read accepted at edge N gives ram_rdata_o/ram_rvalid_o valid after edge N, and the pulse is cleared at edge N+1 unless another read is accepted there.
- A write accepted at edge N is visible to a read accepted at edge N+1.
- ram_oor_o is asserted in the same cycle as the rvalid response, i.e. after the accepting edge. It lasts one cycle.
- No combinational path from inputs to outputs.

## Configuration
- RAM_PARITY_EN defined:
  - Each byte stores an extra even-parity bit, computed on write. The clear sequencer writes the parity of INIT_VAL.
  - An extra output ram_perr_o (1 bit) pulses with ram_rvalid_o when any byte's stored parity mismatches on an in-range read.
  - ram_perr_o resets to 0 and is 0 for out-of-range reads.
- RAM_PARITY_EN undefined: there are no parity bits and no ram_perr_o port.

## Test plan
- Reset release, DEPTH=16, INIT_VAL=32'hA5A5_0000:
  - ram_ready_o goes 1 exactly 16 edges after reset release.
  - Reads of addresses 0..15 return A5A5_0000, each with rvalid one cycle after the request.
- Byte-enable write:
  - Write 32'h1122_3344 to addr 3 with be=4'hF, then 32'hFFFF_FFFF with be=4'b0101.
  - A read of addr 3 returns 32'h11FF_33FF.
- Back-to-back traffic:
  - Write addr 5 = 32'hDEAD_BEEF at N, read addr 5 at N+1, read addr 6 at N+2.
  - rdata is DEAD_BEEF after N+1 and INIT_VAL after N+2, with rvalid high two consecutive cycles.
- Out-of-range with DEPTH=12:
  - Write addr 13 = 32'h1234_5678, then read addr 13.
  - ram_oor_o pulses on both accesses, the read returns 0, and addresses 0..11 are unchanged.
- Reset mid-clear:
  - Assert rst_i for 1 cycle after 7 clear cycles, and issue a write request during CLEAR.
  - ram_ready_o rises 16 edges after the second release, the write has no effect, and all words equal INIT_VAL.
- With RAM_PARITY_EN: force a flipped stored bit in word 2 byte 1 via a hierarchical deposit. A read of addr 2 then pulses ram_perr_o together with ram_rvalid_o.
